// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request/response buses of the IF and MEM clients plus the byte-wide RAM port
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_abort;
    logic              if_done;
    logic [31:0]       if_data;
    logic              mem_req;
    logic              mem_wr;
    logic [1:0]        mem_len;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;
    logic              busy;

    modport slave (
        input  if_req, if_addr, if_abort, mem_req, mem_wr, mem_len, mem_addr, mem_wdata, ram_din,
        output if_done, if_data, mem_done, mem_rdata, ram_dout, ram_a, ram_wr, busy
    );

    modport master (
        output if_req, if_addr, if_abort, mem_req, mem_wr, mem_len, mem_addr, mem_wdata, ram_din,
        input  if_done, if_data, mem_done, mem_rdata, ram_dout, ram_a, ram_wr, busy
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates IF and MEM requests onto a byte-wide RAM and sequences multi-byte accesses
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input logic       clk,
    input logic       rst,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state, state_n;
    logic [2:0]        cnt, cnt_n;
    logic [ADDR_W-1:0] addr, addr_s, ram_a_n;
    logic [1:0]        len, len_s, last, last_s, bi;
    logic              wr, wr_s, own_if, own_s;
    logic [31:0]       wdata, wdata_s, acc, acc_n, if_data_n, mem_rdata_n;
    logic              take_mem, take_if, accept, abort, capture, issue, finish;
    logic [7:0]        ram_dout_n;
    logic              ram_wr_n, if_done_n, mem_done_n, busy_n;

    function automatic logic [1:0] last_of(input logic [1:0] l);
        return l == 2'd0 ? 2'd0 : l == 2'd1 ? 2'd1 : 2'd3;
    endfunction

    // Arbitration (MEM first) and the request parameters that govern the next cycle
    always_comb begin
        take_mem = state == IDLE && bus.mem_req;
        take_if  = state == IDLE && !bus.mem_req && bus.if_req && !bus.if_abort;
        accept   = take_mem || take_if;
        abort    = state == RD && own_if && bus.if_abort;
        addr_s   = take_mem ? bus.mem_addr : take_if ? bus.if_addr : addr;
        len_s    = take_mem ? bus.mem_len : take_if ? 2'd2 : len;
        wr_s     = take_mem ? bus.mem_wr : take_if ? 1'b0 : wr;
        wdata_s  = take_mem ? bus.mem_wdata : wdata;
        own_s    = take_if ? 1'b1 : take_mem ? 1'b0 : own_if;
        last     = last_of(len);
        last_s   = last_of(len_s);
        bi       = 2'(cnt - 3'd1);
        capture  = state == RD && !abort && cnt != 3'd0;
        acc_n    = accept ? 32'd0 : capture ? acc | (32'(bus.ram_din) << {bi, 3'b000}) : acc;
    end

    // Next state: reads run one extra cycle to collect the last byte after its address
    always_comb begin
        state_n = state == IDLE ? (take_mem ? (bus.mem_wr ? WR : RD) : take_if ? RD : IDLE)
                : state == RD   ? (abort ? IDLE : cnt == {1'b0, last} + 3'd1 ? DONE : RD)
                : state == WR   ? (cnt == {1'b0, last} ? DONE : WR)
                : IDLE;
        cnt_n   = (state == IDLE || state_n == IDLE) ? 3'd0 : cnt + 3'd1;
    end

    // Next values of the registered outputs
    always_comb begin
        issue       = (state_n == RD || state_n == WR) && cnt_n <= {1'b0, last_s};
        finish      = state_n == DONE;
        ram_a_n     = issue ? addr_s + ADDR_W'(cnt_n) : '0;
        ram_wr_n    = issue && wr_s;
        ram_dout_n  = ram_wr_n ? 8'(wdata_s >> {cnt_n[1:0], 3'b000}) : 8'd0;
        busy_n      = state_n != IDLE;
        if_done_n   = finish && own_if;
        mem_done_n  = finish && !own_if;
        if_data_n   = if_done_n ? acc_n : bus.if_data;
        mem_rdata_n = mem_done_n && !wr ? acc_n : bus.mem_rdata;
    end

    // State register
    always_ff @(posedge clk) state <= rst ? IDLE : state_n;

    // Latched request, byte accumulator and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            addr          <= '0;
            len           <= '0;
            wr            <= 1'b0;
            wdata         <= '0;
            own_if        <= 1'b0;
            acc           <= '0;
            bus.ram_a     <= '0;
            bus.ram_wr    <= 1'b0;
            bus.ram_dout  <= '0;
            bus.busy      <= 1'b0;
            bus.if_done   <= 1'b0;
            bus.mem_done  <= 1'b0;
            bus.if_data   <= '0;
            bus.mem_rdata <= '0;
        end else begin
            cnt           <= cnt_n;
            addr          <= addr_s;
            len           <= len_s;
            wr            <= wr_s;
            wdata         <= wdata_s;
            own_if        <= own_s;
            acc           <= acc_n;
            bus.ram_a     <= ram_a_n;
            bus.ram_wr    <= ram_wr_n;
            bus.ram_dout  <= ram_dout_n;
            bus.busy      <= busy_n;
            bus.if_done   <= if_done_n;
            bus.mem_done  <= mem_done_n;
            bus.if_data   <= if_data_n;
            bus.mem_rdata <= mem_rdata_n;
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed vector table plus hand-written corner sequences for mem_ctrl
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [7:0] ram [4096];

    typedef struct {
        logic        is_if;
        logic        wr;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          n;
        int          lat;
        logic [31:0] data;
    } vec_t;

    vec_t tbl [9];

    mem_ctrl_if #(.ADDR_W(32)) bus ();
    mem_ctrl #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // RAM model: one-cycle read latency, writes suppressed while reset is asserted
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h13;
        ram[12'h1FF] = 8'h80;
        ram[12'hFFF] = 8'h34;
        ram[12'h000] = 8'h12;
        ram[12'h040] = 8'hAA; ram[12'h041] = 8'hBB; ram[12'h042] = 8'hCC; ram[12'h043] = 8'hDD;
        ram[12'h080] = 8'h01; ram[12'h081] = 8'h02; ram[12'h082] = 8'h03; ram[12'h083] = 8'h04;
        ram[12'h400] = 8'h55; ram[12'h403] = 8'h66;
        bus.ram_din = 8'h00;
        forever begin
            @(posedge clk);
            bus.ram_din <= ram[bus.ram_a[11:0]];
            if (bus.ram_wr && !rst) ram[bus.ram_a[11:0]] = bus.ram_dout;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int id);
        int cyc = 0;
        logic seen = 1'b0;
        if (v.is_if) begin
            bus.if_req = 1'b1;
            bus.if_addr = v.addr;
        end else begin
            bus.mem_req = 1'b1;
            bus.mem_wr = v.wr;
            bus.mem_len = v.len;
            bus.mem_addr = v.addr;
            bus.mem_wdata = v.wdata;
        end
        while (!seen && cyc < 20) begin
            tick();
            cyc++;
            if (cyc <= v.n) begin
                chk($sformatf("v%0d_ram_a_%0d", id, cyc), bus.ram_a, v.addr + 32'(cyc - 1));
                chk($sformatf("v%0d_ram_wr_%0d", id, cyc), {31'b0, bus.ram_wr}, {31'b0, v.wr});
                if (v.wr)
                    chk($sformatf("v%0d_dout_%0d", id, cyc), {24'b0, bus.ram_dout}, {24'b0, 8'(v.wdata >> (8 * (cyc - 1)))});
            end else if (cyc == v.n + 1) begin
                chk($sformatf("v%0d_ram_a_quiet", id), bus.ram_a, 32'h0);
            end
            seen = bus.if_done | bus.mem_done;
        end
        chk($sformatf("v%0d_latency", id), 32'(cyc), 32'(v.lat));
        chk($sformatf("v%0d_owner_done", id), {31'b0, v.is_if ? bus.if_done : bus.mem_done}, 32'h1);
        chk($sformatf("v%0d_other_done", id), {31'b0, v.is_if ? bus.mem_done : bus.if_done}, 32'h0);
        if (!v.wr) chk($sformatf("v%0d_data", id), v.is_if ? bus.if_data : bus.mem_rdata, v.data);
        bus.if_req = 1'b0;
        bus.mem_req = 1'b0;
        tick();
        chk($sformatf("v%0d_idle_busy", id), {31'b0, bus.busy}, 32'h0);
        chk($sformatf("v%0d_idle_done", id), {30'b0, bus.if_done, bus.mem_done}, 32'h0);
    endtask

    initial begin
        int md, id, cyc;
        vec_t v;
        tbl[0] = '{1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         4, 6, 32'h0000_0013};
        tbl[1] = '{1'b0, 1'b0, 2'd0, 32'h0000_01FF, 32'h0,         1, 3, 32'h0000_0080};
        tbl[2] = '{1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0,         2, 4, 32'h0000_1234};
        tbl[3] = '{1'b0, 1'b1, 2'd2, 32'h0000_0300, 32'h1122_3344, 4, 5, 32'h0};
        tbl[4] = '{1'b0, 1'b0, 2'd2, 32'h0000_0300, 32'h0,         4, 6, 32'h1122_3344};
        tbl[5] = '{1'b0, 1'b1, 2'd1, 32'h0000_0401, 32'hAABB_CCDD, 2, 3, 32'h0};
        tbl[6] = '{1'b0, 1'b0, 2'd3, 32'h0000_0400, 32'h0,         4, 6, 32'h66CC_DD55};
        tbl[7] = '{1'b1, 1'b0, 2'd0, 32'h0000_0300, 32'h0,         4, 6, 32'h1122_3344};
        tbl[8] = '{1'b0, 1'b0, 2'd1, 32'h0000_0401, 32'h0,         2, 4, 32'h0000_CCDD};
        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_abort = 1'b0;
        bus.mem_req = 1'b0; bus.mem_wr = 1'b0; bus.mem_len = '0; bus.mem_addr = '0; bus.mem_wdata = '0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_busy", {31'b0, bus.busy}, 32'h0);
        chk("rst_dones", {30'b0, bus.if_done, bus.mem_done}, 32'h0);
        chk("rst_ram_a", bus.ram_a, 32'h0);
        chk("rst_ram_wr", {31'b0, bus.ram_wr}, 32'h0);
        chk("rst_ram_dout", {24'b0, bus.ram_dout}, 32'h0);
        chk("rst_if_data", bus.if_data, 32'h0);
        chk("rst_mem_rdata", bus.mem_rdata, 32'h0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 9; i++) run(tbl[i], i);
        chk("st_0x300", {ram[12'h303], ram[12'h302], ram[12'h301], ram[12'h300]}, 32'h1122_3344);

        // simultaneous MEM store and IF fetch: MEM wins, IF follows
        bus.mem_req = 1'b1; bus.mem_wr = 1'b1; bus.mem_len = 2'd2;
        bus.mem_addr = 32'h200; bus.mem_wdata = 32'hDEAD_BEEF;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        md = 0; id = 0;
        for (int c = 1; c <= 30 && id == 0; c++) begin
            tick();
            if (c <= 4) begin
                chk($sformatf("arb_ram_a_%0d", c), bus.ram_a, 32'h200 + 32'(c - 1));
                chk($sformatf("arb_ram_wr_%0d", c), {31'b0, bus.ram_wr}, 32'h1);
            end
            if (bus.mem_done) begin md = c; bus.mem_req = 1'b0; end
            if (bus.if_done) begin id = c; bus.if_req = 1'b0; end
        end
        chk("arb_mem_done_cycle", 32'(md), 32'd5);
        chk("arb_if_done_cycle", 32'(id), 32'd12);
        chk("arb_if_data", bus.if_data, 32'h0000_0013);
        chk("arb_ram", {ram[12'h203], ram[12'h202], ram[12'h201], ram[12'h200]}, 32'hDEAD_BEEF);
        tick();
        chk("arb_done_once", {31'b0, bus.if_done}, 32'h0);

        // IF abort in the middle of a fetch, then a clean re-fetch
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        tick(); tick();
        bus.if_abort = 1'b1;
        tick();
        chk("abort_busy", {31'b0, bus.busy}, 32'h0);
        chk("abort_no_done", {31'b0, bus.if_done}, 32'h0);
        chk("abort_if_data_kept", bus.if_data, 32'h0000_0013);
        bus.if_abort = 1'b0; bus.if_addr = 32'h80;
        cyc = 0;
        while (!bus.if_done && cyc < 20) begin tick(); cyc++; end
        chk("refetch_latency", 32'(cyc), 32'd6);
        chk("refetch_data", bus.if_data, 32'h0403_0201);
        bus.if_req = 1'b0;
        tick();

        // reset in the middle of a 4-byte store
        bus.mem_req = 1'b1; bus.mem_wr = 1'b1; bus.mem_len = 2'd3;
        bus.mem_addr = 32'h500; bus.mem_wdata = 32'h0A0B_0C0D;
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("rstmid_ram_wr", {31'b0, bus.ram_wr}, 32'h0);
        chk("rstmid_busy", {31'b0, bus.busy}, 32'h0);
        chk("rstmid_if_data", bus.if_data, 32'h0);
        rst = 1'b0; bus.mem_req = 1'b0;
        md = 0;
        for (int c = 0; c < 6; c++) begin tick(); md += int'(bus.mem_done); end
        chk("rstmid_no_done", 32'(md), 32'd0);
        chk("rstmid_ram", {ram[12'h503], ram[12'h502], ram[12'h501], ram[12'h500]}, 32'h0000_000D);

        // if_abort ignored by a MEM load
        bus.if_abort = 1'b1;
        v = '{1'b0, 1'b0, 2'd2, 32'h0000_0080, 32'h0, 4, 6, 32'h0403_0201};
        run(v, 9);
        bus.if_abort = 1'b0;

        // if_abort during DONE of an IF fetch still yields one if_done
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        cyc = 0;
        while (!bus.if_done && cyc < 20) begin tick(); cyc++; end
        chk("done_abort_latency", 32'(cyc), 32'd6);
        chk("done_abort_data", bus.if_data, 32'hDDCC_BBAA);
        bus.if_abort = 1'b1; bus.if_req = 1'b0;
        tick();
        chk("done_abort_once", {31'b0, bus.if_done}, 32'h0);
        chk("done_abort_idle", {31'b0, bus.busy}, 32'h0);
        bus.if_abort = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port arbiter and sequencer between the instruction-fetch unit (IF) and the MEM stage for the byte-wide RAM.
- The MEM stage consumes the load/store address and op that EX produces.
- Converts one word/half/byte request into a sequence of byte accesses with one-cycle RAM read latency, then returns assembled data with a one-cycle done pulse.
- Handles branch-flush abort of an in-flight fetch.

Parameters:
ADDR_W, 32, width of every address bus (byte addresses, wrap modulo 2^ADDR_W)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
if_req  input  1  IF requests a 4-byte instruction read; held until if_done sampled
if_addr  input  ADDR_W  IF fetch address
if_abort  input  1  flush: cancel the in-flight IF fetch
if_done  output  1  one-cycle pulse, if_data valid
if_data  output  32  fetched instruction, little-endian
mem_req  input  1  MEM stage access request; held until mem_done sampled
mem_wr  input  1  1 = store, 0 = load
mem_len  input  2  0 = 1 byte, 1 = 2 bytes, 2 or 3 = 4 bytes
mem_addr  input  ADDR_W  load/store byte address
mem_wdata  input  32  store data; byte k = mem_wdata[8k+7:8k]
mem_done  output  1  one-cycle pulse, access complete (mem_rdata valid for loads)
mem_rdata  output  32  load data, zero-extended raw bytes (sign extension done by MEM stage)
ram_din  input  8  RAM read data, valid one cycle after its address was driven
ram_dout  output  8  RAM write data
ram_a  output  ADDR_W  RAM byte address
ram_wr  output  1  RAM write enable (1 = write)
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE; all outputs 0 from the next cycle and held 0 while rst=1. Aborts any access mid-sequence; no done pulse for it.
- States: IDLE, RD, WR, DONE. All outputs registered.
- IDLE arbitration:
  - mem_req has strict priority over if_req.
  - Accepted request's addr, len, wr and wdata are latched at the accepting edge (cycle t); owner recorded.
  - IF request is always a 4-byte read.
  - if_req with if_abort=1 in the same cycle is not accepted.
- Byte count: N = 1/2/4 from len. Byte k address = latched addr + k, ADDR_W-bit wrap. No alignment check.
- RD:
  - Issues byte k on ram_a in cycle t+1+k, k = 0..N-1, with ram_wr=0.
  - Byte k is captured from ram_din at the end of cycle t+2+k into data[8k+7:8k].
  - Unused upper bytes = 0.
  - Last capture at end of t+N+1 -> DONE in cycle t+N+2.
  - Accept-to-done latency = N+2 cycles.
- WR:
  - Drives ram_a = addr+k, ram_dout = wdata byte k, ram_wr=1 in cycle t+1+k.
  - DONE in cycle t+N+1.
  - Accept-to-done latency = N+1 cycles.
- DONE:
  - Exactly one cycle; pulses the owner's done; data output already stable.
  - Requests are ignored in this cycle.
  - Next state IDLE. Requester must drop req on the cycle after done.
- if_data / mem_rdata hold their last value until the next completion of the same owner.
- When not issuing: ram_a=0, ram_wr=0, ram_dout=0.
- if_abort while owner=IF in RD:
  - Next state IDLE; if_done is never pulsed for that fetch.
  - Pending byte on ram_din is discarded; if_data unchanged.
  - IF may re-request from the following IDLE cycle.
- if_abort in DONE with owner=IF: if_done still pulses; the IF unit discards.
- if_abort has no effect on MEM-owned accesses or in IDLE.
- mem_req arriving during an IF access waits, at most one IF access + DONE. if_req waits behind MEM likewise. No preemption.

Test Plan:
1. Reset, then if_req=1, if_addr=0x100, RAM bytes 0x100..0x103 = 13,00,00,00 -> ram_a 0x100..0x103 on cycles t+1..t+4; if_done high only in t+6 with if_data=0x00000013; ram_wr=0 throughout.
2. mem_req and if_req both high in the same IDLE cycle, mem_wr=1, mem_len=2, mem_addr=0x200, mem_wdata=0xDEADBEEF -> writes EF,BE,AD,DE to 0x200..0x203 with ram_wr=1; mem_done at t+5; IF accepted at t+6; if_done at t+12.
3. Load mem_len=0 at 0x1FF with RAM[0x1FF]=0x80 -> mem_done at t+3, mem_rdata=0x00000080. Then mem_len=1 at 0xFFFFFFFF -> byte addresses 0xFFFFFFFF then 0x00000000.
4. IF fetch at 0x40; if_abort=1 in cycle t+2 -> busy low at t+3, no if_done. A new fetch at 0x80 accepted from the next IDLE completes correctly; if_data is not corrupted by the aborted bytes.
5. rst=1 in cycle t+2 of a 4-byte store -> from t+3 ram_wr=0 and busy=0; no mem_done; only the byte issued at t+1 was written.
6. if_abort asserted during a MEM load, and in DONE of an IF fetch -> the load completes normally; if_done still pulses once.
